// File: rtl/rally_controller.sv
// Ping-pong game sequencer: serve/rally/point/game-over flow and score keeping.
// All timing is counted in frame_tick pulses; outputs come from registered state.
module rally_controller #(
   parameter int WIN_SCORE   = 7,
   parameter int SCORE_W     = 4,
   parameter int SERVE_DELAY = 60,
   parameter int POINT_DELAY = 30,
   parameter int DLY_W       = 8
) (
   input  logic               sys_clock,
   input  logic               reset,
   input  logic               start,
   input  logic               frame_tick,
   input  logic               miss_l,
   input  logic               miss_r,
   output logic [SCORE_W-1:0] sc1,
   output logic [SCORE_W-1:0] sc2,
   output logic               reset_game,
   output logic               ball_en,
   output logic               serve_dir,
   output logic [1:0]         winner,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_RALLY = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam logic [DLY_W-1:0]   SD_LAST = DLY_W'(SERVE_DELAY - 1);
   localparam logic [DLY_W-1:0]   PD_LAST = DLY_W'(POINT_DELAY - 1);
   localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

   state_t             r_state, w_state_nxt;
   logic [SCORE_W-1:0] r_sc1, w_sc1_nxt;
   logic [SCORE_W-1:0] r_sc2, w_sc2_nxt;
   logic               r_serve_dir, w_serve_dir_nxt;
   logic [1:0]         r_winner, w_winner_nxt;
   logic [DLY_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_start_q;
   logic               w_start_rise;
   logic               w_delay_st;

   assign w_start_rise = start & ~r_start_q;
   assign w_delay_st   = (r_state == S_SERVE) || (r_state == S_POINT);

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sc1       <= '0;
         r_sc2       <= '0;
         r_serve_dir <= 1'b0;
         r_winner    <= 2'b00;
         r_cnt       <= '0;
         r_start_q   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sc1       <= w_sc1_nxt;
         r_sc2       <= w_sc2_nxt;
         r_serve_dir <= w_serve_dir_nxt;
         r_winner    <= w_winner_nxt;
         r_cnt       <= w_cnt_nxt;
         r_start_q   <= start;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_sc1_nxt       = r_sc1;
      w_sc2_nxt       = r_sc2;
      w_serve_dir_nxt = r_serve_dir;
      w_winner_nxt    = r_winner;
      w_cnt_nxt       = (frame_tick && w_delay_st) ? r_cnt + 1'b1 : r_cnt;
      unique case (r_state)
         S_IDLE, S_OVER: begin
            if (w_start_rise) begin
               w_state_nxt     = S_SERVE;
               w_sc1_nxt       = '0;
               w_sc2_nxt       = '0;
               w_serve_dir_nxt = 1'b0;
               w_winner_nxt    = 2'b00;
            end
         end
         S_SERVE: begin
            if (frame_tick && r_cnt == SD_LAST)
               w_state_nxt = S_RALLY;
         end
         S_RALLY: begin
            if (miss_l && miss_r) begin
               w_state_nxt = S_SERVE;
            end else if (miss_l) begin
               w_sc2_nxt       = r_sc2 + 1'b1;
               w_serve_dir_nxt = 1'b0;
               w_state_nxt     = S_POINT;
            end else if (miss_r) begin
               w_sc1_nxt       = r_sc1 + 1'b1;
               w_serve_dir_nxt = 1'b1;
               w_state_nxt     = S_POINT;
            end
         end
         S_POINT: begin
            if (frame_tick && r_cnt == PD_LAST) begin
               if (r_sc1 == WIN) begin
                  w_state_nxt  = S_OVER;
                  w_winner_nxt = 2'b01;
               end else if (r_sc2 == WIN) begin
                  w_state_nxt  = S_OVER;
                  w_winner_nxt = 2'b10;
               end else begin
                  w_state_nxt = S_SERVE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Every transition restarts the frame delay; an entry-cycle tick is dropped.
      if (w_state_nxt != r_state)
         w_cnt_nxt = '0;
   end

   assign sc1        = r_sc1;
   assign sc2        = r_sc2;
   assign serve_dir  = r_serve_dir;
   assign winner     = r_winner;
   assign state      = r_state;
   assign ball_en    = (r_state == S_RALLY);
   assign reset_game = (r_state != S_RALLY);

endmodule

// File: tb/tb_rally_controller.sv
// Directed bench for rally_controller with WIN_SCORE=3 and 2-tick delays.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_rally_controller;

   logic       sys_clock;
   logic       reset;
   logic       start;
   logic       frame_tick;
   logic       miss_l;
   logic       miss_r;
   logic [3:0] sc1;
   logic [3:0] sc2;
   logic       reset_game;
   logic       ball_en;
   logic       serve_dir;
   logic [1:0] winner;
   logic [2:0] state;

   int passed = 0;
   int total  = 0;

   rally_controller #(
      .WIN_SCORE  (3),
      .SCORE_W    (4),
      .SERVE_DELAY(2),
      .POINT_DELAY(2),
      .DLY_W      (8)
   ) dut (
      .sys_clock (sys_clock),
      .reset     (reset),
      .start     (start),
      .frame_tick(frame_tick),
      .miss_l    (miss_l),
      .miss_r    (miss_r),
      .sc1       (sc1),
      .sc2       (sc2),
      .reset_game(reset_game),
      .ball_en   (ball_en),
      .serve_dir (serve_dir),
      .winner    (winner),
      .state     (state)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st,
                          input logic [3:0] s1, input logic [3:0] s2,
                          input logic sd, input logic [1:0] w);
      chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
      chk({tag, ".sc1"}, {4'd0, sc1}, {4'd0, s1});
      chk({tag, ".sc2"}, {4'd0, sc2}, {4'd0, s2});
      chk({tag, ".dir"}, {7'd0, serve_dir}, {7'd0, sd});
      chk({tag, ".win"}, {6'd0, winner}, {6'd0, w});
      chk({tag, ".rg"}, {7'd0, reset_game}, {7'd0, (st != 3'd2)});
      chk({tag, ".ben"}, {7'd0, ball_en}, {7'd0, (st == 3'd2)});
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      frame_tick = 1'b0;
      miss_l     = 1'b0;
      miss_r     = 1'b0;
      #12;
      chk_all("reset", 3'd0, 4'd0, 4'd0, 1'b0, 2'b00);
      @(posedge sys_clock);
      #1 reset = 1'b0;
      step();
      chk_all("idle", 3'd0, 4'd0, 4'd0, 1'b0, 2'b00);

      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("t1.serve", 3'd1, 4'd0, 4'd0, 1'b0, 2'b00);
      tick();
      chk_all("t1.tick1", 3'd1, 4'd0, 4'd0, 1'b0, 2'b00);
      step();
      chk_all("t1.notick", 3'd1, 4'd0, 4'd0, 1'b0, 2'b00);
      tick();
      chk_all("t1.rally", 3'd2, 4'd0, 4'd0, 1'b0, 2'b00);

      miss_r = 1'b1;
      step();
      miss_r = 1'b0;
      chk_all("t2.point", 3'd3, 4'd1, 4'd0, 1'b1, 2'b00);
      tick();
      chk_all("t2.tick1", 3'd3, 4'd1, 4'd0, 1'b1, 2'b00);
      tick();
      chk_all("t2.serve", 3'd1, 4'd1, 4'd0, 1'b1, 2'b00);
      tick();
      tick();
      chk_all("t2.rally", 3'd2, 4'd1, 4'd0, 1'b1, 2'b00);

      miss_l = 1'b1;
      miss_r = 1'b1;
      step();
      miss_l = 1'b0;
      miss_r = 1'b0;
      chk_all("t4.replay", 3'd1, 4'd1, 4'd0, 1'b1, 2'b00);
      tick();
      tick();
      chk_all("t4.rally", 3'd2, 4'd1, 4'd0, 1'b1, 2'b00);

      miss_l = 1'b1;
      step();
      miss_l = 1'b0;
      chk_all("t3.p1", 3'd3, 4'd1, 4'd1, 1'b0, 2'b00);
      tick();
      tick();
      chk_all("t3.s1", 3'd1, 4'd1, 4'd1, 1'b0, 2'b00);
      tick();
      tick();
      miss_l = 1'b1;
      step();
      miss_l = 1'b0;
      chk_all("t3.p2", 3'd3, 4'd1, 4'd2, 1'b0, 2'b00);
      tick();
      tick();
      tick();
      tick();
      chk_all("t3.r3", 3'd2, 4'd1, 4'd2, 1'b0, 2'b00);
      miss_l = 1'b1;
      step();
      miss_l = 1'b0;
      chk_all("t3.p3", 3'd3, 4'd1, 4'd3, 1'b0, 2'b00);
      tick();
      chk_all("t3.hold", 3'd3, 4'd1, 4'd3, 1'b0, 2'b00);
      tick();
      chk_all("t3.over", 3'd4, 4'd1, 4'd3, 1'b0, 2'b10);
      miss_l = 1'b1;
      tick();
      miss_l = 1'b0;
      miss_r = 1'b1;
      tick();
      miss_r = 1'b0;
      chk_all("t3.frozen", 3'd4, 4'd1, 4'd3, 1'b0, 2'b10);

      start = 1'b1;
      step();
      chk_all("t5.restart", 3'd1, 4'd0, 4'd0, 1'b0, 2'b00);
      miss_l = 1'b1;
      step();
      miss_l = 1'b0;
      chk_all("t5.misssrv", 3'd1, 4'd0, 4'd0, 1'b0, 2'b00);
      tick();
      tick();
      chk_all("t5.rally", 3'd2, 4'd0, 4'd0, 1'b0, 2'b00);
      start = 1'b0;
      miss_r = 1'b1;
      step();
      miss_r = 1'b0;
      chk_all("t5.point", 3'd3, 4'd1, 4'd0, 1'b1, 2'b00);
      miss_l = 1'b1;
      start  = 1'b1;
      step();
      miss_l = 1'b0;
      start  = 1'b0;
      chk_all("t5.misspt", 3'd3, 4'd1, 4'd0, 1'b1, 2'b00);
      tick();
      tick();
      tick();
      tick();
      chk_all("t5.rally2", 3'd2, 4'd1, 4'd0, 1'b1, 2'b00);
      miss_r = 1'b1;
      step();
      miss_r = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk_all("t6.pre", 3'd2, 4'd2, 4'd0, 1'b1, 2'b00);

      reset = 1'b1;
      #1;
      chk_all("t6.async", 3'd0, 4'd0, 4'd0, 1'b0, 2'b00);
      step();
      reset = 1'b0;
      step();
      chk_all("t6.idle", 3'd0, 4'd0, 4'd0, 1'b0, 2'b00);

      start      = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk_all("t5.held", 3'd1, 4'd0, 4'd0, 1'b0, 2'b00);
      tick();
      chk_all("entry.tick", 3'd1, 4'd0, 4'd0, 1'b0, 2'b00);
      tick();
      chk_all("held.rally", 3'd2, 4'd0, 4'd0, 1'b0, 2'b00);
      start = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
